booth_seq_ctrl: RTL and testbench
=================================

# booth_seq_ctrl

Sequential radix-4 Booth multiplier controller for signed WIDTH×WIDTH operands, with valid/ready handshakes on input and output. It holds the operands and a 2·WIDTH-bit accumulator, then issues one Booth digit per cycle: encode, form the partial product, add. This replaces the fully combinational four-partial-product multiplier wherever area matters more than latency. It sits between a requesting datapath stage and the result consumer.

## Interface
- WIDTH, default 8: operand width. Must be even and ≥4. D = WIDTH/2 is the number of Booth digits.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operands.
- mcand_i  in  WIDTH  signed multiplicand.
- mplier_i  in  WIDTH  signed multiplier.
- out_valid_o  out  1  product valid.
- out_ready_i  in  1  consumer accepts the product.
- prod_o  out  2·WIDTH  signed product.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: capture mcand_i and mplier_i, clear acc, set k=0, go to RUN.
- RUN, one digit per cycle:
  - Window = {mplier[2k+1], mplier[2k], mplier[2k-1]}, with mplier[-1]=0.
  - Digit map: 000/111→0, 001/010→+1, 011→+2, 100→−2, 101/110→−1.
  - Partial product: mcand sign-extended to 2·WIDTH, ×2 by 1-bit shift, negated by two's complement, then shifted left by 2k.
  - acc += pp, modulo 2^(2·WIDTH). The final result is exact.
  - After digit k=D−1, go to DONE.
- DONE:
  - out_valid_o=1 and prod_o=acc, both held stable.
  - On out_ready_i: go to IDLE.
- Captured operands are immune to later changes on the inputs.
- in_valid_i outside IDLE is ignored (in_ready_o=0). The requester must hold its request.
- out_ready_i outside DONE is ignored.
- Reset, at any time including mid-RUN or DONE:
  - Immediately: state=IDLE, acc=0, k=0, operands=0.
  - Outputs: out_valid_o=0, prod_o=0, in_ready_o=1.
  - An in-flight operation is discarded without any output.

## Timing
- Accept at edge t0. The D digit additions occur at edges t1..tD. out_valid_o rises after edge tD, so latency is D cycles (4 for WIDTH=8).
- Output handshake at edge tH returns the block to IDLE. in_ready_o=1 from tH.
- Minimum accept-to-accept interval: D+2 cycles. There is no overlap of operations.
- prod_o is registered (it is acc). prod_o=0 whenever the block is not in DONE after reset; its value in IDLE/RUN after a completed operation is acc, and only DONE is meaningful.

## Configuration
- BOOTH_EARLY_EXIT_EN defined:
  - Condition, checked at the start of each RUN cycle for digit k: mplier bits [WIDTH−1:2k−1] are all equal (bit −1=0). This means all remaining digits are zero.
  - If the condition holds, go to DONE that cycle without adding.
  - Resulting latency: (first such k)+1 cycles, with a maximum of D.
  - Examples: mplier=0 → 1 cycle; mplier=1 → 2 cycles; mplier=−1 → 2 cycles.
- BOOTH_EARLY_EXIT_EN undefined: always D RUN cycles, with a fixed latency of D.

## Structure
- Package booth_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - digit_t enum {DIG_Z, DIG_P1, DIG_P2, DIG_M1, DIG_M2}.
- Sub-module booth_digit_enc: 3-bit window → digit_t. Purely combinational, one instance.
- Partial-product generation, accumulator, k counter and FSM live in booth_seq_ctrl.

## Test plan
All scenarios use WIDTH=8.
- 3×5 with out_ready_i=1 → prod_o=0x000F. out_valid_o rises exactly 4 cycles after accept, then IDLE next cycle.
- −128×−128 → 0x4000. 127×−128 → 0xC080. −1×−1 → 0x0001.
- Backpressure:
  - 6×7, out_ready_i=0 for 3 cycles in DONE → prod_o holds 0x002A and out_valid_o stays 1.
  - in_valid_i with 2×2 in that window is not accepted (in_ready_o=0) and is accepted only after return to IDLE → 0x0004.
- rst_i pulsed during the second RUN cycle of 100×100:
  - Outputs go to 0 and the FSM to IDLE immediately; no out_valid_o.
  - Next op 7×−3 → 0xFFEB with 4-cycle latency.
- Back-to-back ops with in_valid_i held high → accept interval 6 cycles; results in order.
- With BOOTH_EARLY_EXIT_EN: 5×0 → 0x0000 in 1 cycle; 5×1 → 0x0005 in 2 cycles; 5×−1 → 0xFFFB in 2 cycles; 5×64 → 0x0140 in 4 cycles. Without the macro, all take 4 cycles with identical products.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit encoding and small helpers for digit decoding.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DIG_Z  = 3'd0,
        DIG_P1 = 3'd1,
        DIG_P2 = 3'd2,
        DIG_M1 = 3'd3,
        DIG_M2 = 3'd4
    } digit_t;

    // True for digits whose partial product is the doubled multiplicand.
    function automatic logic digit_is_double(input digit_t dig);
        return (dig == DIG_P2) || (dig == DIG_M2);
    endfunction

    // True for digits whose partial product must be negated.
    function automatic logic digit_is_negative(input digit_t dig);
        return (dig == DIG_M1) || (dig == DIG_M2);
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth digit encoder: maps a 3-bit multiplier window
// {b[2k+1], b[2k], b[2k-1]} onto a signed digit in {-2,-1,0,+1,+2}.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output digit_t     digit
);

    // Standard Booth recoding table.
    always_comb begin
        digit = DIG_Z;
        case (window)
            3'b000:  digit = DIG_Z;
            3'b001:  digit = DIG_P1;
            3'b010:  digit = DIG_P1;
            3'b011:  digit = DIG_P2;
            3'b100:  digit = DIG_M2;
            3'b101:  digit = DIG_M1;
            3'b110:  digit = DIG_M1;
            3'b111:  digit = DIG_Z;
            default: digit = DIG_Z;
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier for signed WIDTH x WIDTH operands.
// Accepts one operand pair in IDLE, retires one Booth digit per RUN cycle
// into a 2*WIDTH accumulator, then presents the product in DONE until the
// consumer takes it.
// Optional build macro: BOOTH_EARLY_EXIT_EN -- leave RUN as soon as every
// remaining Booth digit is known to be zero.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int D  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int KW = (D > 1) ? $clog2(D) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(D - 1);

    state_t            state_reg, state_next;
    logic [PW-1:0]     acc_reg, acc_next;
    logic [KW-1:0]     k_reg, k_next;
    logic [WIDTH-1:0]  mcand_reg, mcand_next;
    logic [WIDTH-1:0]  mplier_reg, mplier_next;

    // Multiplier with the implicit bit -1 (always zero) appended at the LSB,
    // so window k sits at mplier_ext[2k+2:2k].
    logic [WIDTH:0]    mplier_ext;
    logic [2:0]        window;
    digit_t            digit;
    logic [PW-1:0]     mcand_sext;
    logic [PW-1:0]     pp_mag;
    logic [PW-1:0]     pp_signed;
    logic [PW-1:0]     pp_shifted;
    logic              early_exit;

    assign mplier_ext = {mplier_reg, 1'b0};
    assign window     = mplier_ext[{k_reg, 1'b0} +: 3];

    booth_digit_enc u_digit_enc (
        .window (window),
        .digit  (digit)
    );

    // Partial product: sign-extend, optionally double, optionally negate,
    // then weight by 4^k.
    always_comb begin
        mcand_sext = {{WIDTH{mcand_reg[WIDTH-1]}}, mcand_reg};
        pp_mag     = digit_is_double(digit) ? (mcand_sext << 1) : mcand_sext;
        if (digit == DIG_Z) begin
            pp_signed = '0;
        end else if (digit_is_negative(digit)) begin
            pp_signed = (~pp_mag) + PW'(1);
        end else begin
            pp_signed = pp_mag;
        end
        pp_shifted = pp_signed << {k_reg, 1'b0};
    end

`ifdef BOOTH_EARLY_EXIT_EN
    // rest_uniform[gi]: multiplier bits [WIDTH-1 : 2*gi-1] are all equal,
    // meaning digits gi..D-1 all recode to zero.
    logic [D-1:0] rest_uniform;

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_uniform
            assign rest_uniform[gi] = (&mplier_ext[WIDTH:2*gi]) |
                                      ~(|mplier_ext[WIDTH:2*gi]);
        end
    endgenerate

    assign early_exit = rest_uniform[k_reg];
`else
    assign early_exit = 1'b0;
`endif

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            k_reg      <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            k_reg      <= k_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
        end
    end

    // Next-state and datapath update: capture in IDLE, one digit per RUN
    // cycle, hold in DONE until the consumer accepts.
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        k_next      = k_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid_i) begin
                    mcand_next  = mcand_i;
                    mplier_next = mplier_i;
                    acc_next    = '0;
                    k_next      = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (early_exit) begin
                    k_next     = '0;
                    state_next = DONE;
                end else begin
                    acc_next = acc_reg + pp_shifted;
                    if (k_reg == K_LAST) begin
                        k_next     = '0;
                        state_next = DONE;
                    end else begin
                        k_next = k_reg + KW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The product is the accumulator itself, so it is registered and stable
    // for as long as DONE lasts.
    assign in_ready_o  = (state_reg == IDLE);
    assign out_valid_o = (state_reg == DONE);
    assign prod_o      = acc_reg;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH=8) with directed vectors.
// Expected latencies for the early-exit cases follow BOOTH_EARLY_EXIT_EN.
module tb_booth_seq_ctrl;

    localparam int WIDTH = 8;

    logic         clk_i;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   mcand_i;
    logic [7:0]   mplier_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [15:0]  prod_o;

    int checks;
    int errors;

    booth_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mcand_i     (mcand_i),
        .mplier_i    (mplier_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .prod_o      (prod_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full operation: accept, wait for product, check latency/value, handshake.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_prod, input int exp_lat,
                         input string name);
        int lat;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b want 1", name, in_ready_o);
        end
        in_valid_i = 1'b1;
        mcand_i    = a;
        mplier_i   = b;
        tick();
        in_valid_i = 1'b0;
        mcand_i    = 8'hA5;   // captured operands must not follow the inputs
        mplier_i   = 8'h5A;
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (prod_o !== exp_prod) begin
            errors++;
            $display("FAIL %s prod got %h want %h", name, prod_o, exp_prod);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s return_idle got valid=%b ready=%b want valid=0 ready=1",
                     name, out_valid_o, in_ready_o);
        end
        $display("op %s: %h x %h -> %h latency %0d", name, a, b, prod_o, lat);
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        mcand_i     = '0;
        mplier_i    = '0;
        tick();
        tick();
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || prod_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got ready=%b valid=%b prod=%h want 1 0 0000",
                     in_ready_o, out_valid_o, prod_o);
        end
        rst_i = 1'b0;
        tick();
        $display("reset: ready=%b valid=%b prod=%h", in_ready_o, out_valid_o, prod_o);
    endtask

    task automatic test_basic();
        do_op(8'd3,    8'd5,    16'h000F, 4, "3x5");
        do_op(8'h80,   8'h80,   16'h4000, 4, "m128xm128");
        do_op(8'd127,  8'h80,   16'hC080, 4, "127xm128");
        do_op(8'hFF,   8'hFF,   16'h0001, 4, "m1xm1");
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid_i = 1'b1;
        mcand_i    = 8'd6;
        mplier_i   = 8'd7;
        tick();
        mcand_i  = 8'd2;      // competing request held during the whole op
        mplier_i = 8'd2;
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 20) begin
            checks++;
            if (in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_run_ready got %b want 0", in_ready_o);
            end
            tick();
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL bp_latency got %0d want 4", lat);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid_o !== 1'b1 || prod_o !== 16'h002A || in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b prod=%h ready=%b want 1 002a 0",
                         i, out_valid_o, prod_o, in_ready_o);
            end
            $display("bp hold %0d: valid=%b prod=%h ready=%b", i, out_valid_o, prod_o, in_ready_o);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got ready=%b valid=%b want 1 0", in_ready_o, out_valid_o);
        end
        tick();               // 2x2 is accepted at this edge, not earlier
        in_valid_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept got ready=%b want 0", in_ready_o);
        end
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4 || prod_o !== 16'h0004) begin
            errors++;
            $display("FAIL bp_2x2 got prod=%h lat=%0d want 0004 4", prod_o, lat);
        end
        $display("bp 2x2: prod=%h latency %0d", prod_o, lat);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset_midrun();
        in_valid_i = 1'b1;
        mcand_i    = 8'd100;
        mplier_i   = 8'd100;
        tick();               // accept
        in_valid_i = 1'b0;
        tick();               // now in second RUN cycle
        rst_i = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || prod_o !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset got ready=%b valid=%b prod=%h want 1 0 0000",
                     in_ready_o, out_valid_o, prod_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL midrun_discard cycle %0d got valid=%b ready=%b want 0 1",
                         i, out_valid_o, in_ready_o);
            end
            tick();
        end
        $display("midrun reset: idle ready=%b valid=%b", in_ready_o, out_valid_o);
        do_op(8'd7, 8'hFD, 16'hFFEB, 4, "7xm3_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a_tab [3];
        logic [7:0]  b_tab [3];
        logic [15:0] p_tab [3];
        int acc_cyc [3];
        int op_idx;
        int res_idx;
        int cyc;
        a_tab = '{8'd3,  8'hFE, 8'd12};
        b_tab = '{8'h80, 8'd100, 8'd127};
        p_tab = '{16'hFE80, 16'hFF38, 16'h05F4};
        op_idx  = 0;
        res_idx = 0;
        cyc     = 0;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        mcand_i     = a_tab[0];
        mplier_i    = b_tab[0];
        while (res_idx < 3 && cyc < 60) begin
            if (out_valid_o === 1'b1) begin
                checks++;
                if (prod_o !== p_tab[res_idx]) begin
                    errors++;
                    $display("FAIL b2b_result %0d got %h want %h", res_idx, prod_o, p_tab[res_idx]);
                end
                $display("b2b result %0d: %h", res_idx, prod_o);
                res_idx++;
            end
            if (in_valid_i && in_ready_o === 1'b1 && op_idx < 3) begin
                acc_cyc[op_idx] = cyc;
                op_idx++;
                tick();
                if (op_idx < 3) begin
                    mcand_i  = a_tab[op_idx];
                    mplier_i = b_tab[op_idx];
                end else begin
                    in_valid_i = 1'b0;
                end
            end else begin
                tick();
            end
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        checks++;
        if (res_idx != 3) begin
            errors++;
            $display("FAIL b2b_timeout got %0d results want 3", res_idx);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                    errors++;
                    $display("FAIL b2b_interval %0d got %0d want 6", i, acc_cyc[i] - acc_cyc[i-1]);
                end
                $display("b2b accept interval %0d: %0d", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        tick();
    endtask

    task automatic test_early_exit();
`ifdef BOOTH_EARLY_EXIT_EN
        do_op(8'd5, 8'd0,  16'h0000, 1, "5x0");
        do_op(8'd5, 8'd1,  16'h0005, 2, "5x1");
        do_op(8'd5, 8'hFF, 16'hFFFB, 2, "5xm1");
`else
        do_op(8'd5, 8'd0,  16'h0000, 4, "5x0");
        do_op(8'd5, 8'd1,  16'h0005, 4, "5x1");
        do_op(8'd5, 8'hFF, 16'hFFFB, 4, "5xm1");
`endif
        do_op(8'd5, 8'd64, 16'h0140, 4, "5x64");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_early_exit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
